// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared FSM state type and width helper for serial arithmetic blocks
package arith_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed for a counter that must hold values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sub_serial_nbit_if.sv
// rtl/sub_serial_nbit_if.sv - start/done request bus for the serial subtractor
interface sub_serial_nbit_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
endinterface

// File: rtl/som_comp_1bit.sv
// rtl/som_comp_1bit.sv - 1-bit full adder bit-slice
module som_comp_1bit (
    input  logic x,
    input  logic y,
    input  logic Cin,
    output logic A,
    output logic Cout
);
    assign A    = x ^ y ^ Cin;
    assign Cout = (x & y) | (Cin & (x ^ y));
endmodule

// File: rtl/sub_serial_nbit.sv
// rtl/sub_serial_nbit.sv - bit-serial N-bit subtractor computing a + ~b + 1 LSB first
module sub_serial_nbit
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    sub_serial_nbit_if.slave   bus
);
    localparam int CW = cnt_width(N);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]    state_q,  state_d;
    logic [N-1:0]  a_sh_q,   a_sh_d;
    logic [N-1:0]  b_sh_q,   b_sh_d;
    logic [N-1:0]  res_sh_q, res_sh_d;
    logic          cy_q,     cy_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          a_msb_q,  a_msb_d;
    logic          b_msb_q,  b_msb_d;
    logic [N-1:0]  diff_q,   diff_d;
    logic          borrow_q, borrow_d;
    logic          ovf_q,    ovf_d;
    logic          done_q,   done_d;

    logic          b_inv;
    logic          fa_sum;
    logic          fa_cout;
    logic [N-1:0]  res_next;

    // Subtraction is addition of the inverted subtrahend; the +1 enters as the initial carry
    assign b_inv = ~b_sh_q[0];

    som_comp_1bit u_fa (
        .x    (a_sh_q[0]),
        .y    (b_inv),
        .Cin  (cy_q),
        .A    (fa_sum),
        .Cout (fa_cout)
    );

    // New sum bit enters at the MSB so after N shifts bit 0 sits at position 0;
    // written as shift/or so the N=1 case needs no empty slice
    assign res_next = (res_sh_q >> 1) | (N'(fa_sum) << (N - 1));

    // Next-state: capture operands in IDLE, one bit per cycle in RUN, publish results on the last bit
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    cy_d    = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = bus.a[N-1];
                    b_msb_d = bus.b[N-1];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                cy_d     = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    diff_d   = res_next;
                    borrow_d = ~fa_cout;
                    // Overflow only possible when operand signs differ and the result sign leaves a's sign
                    ovf_d    = (a_msb_q != b_msb_q) && (fa_sum != a_msb_q);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset clearing everything, including published results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_sub_serial_nbit.sv
// tb/tb_sub_serial_nbit.sv - self-checking bench for sub_serial_nbit
module tb_sub_serial_nbit;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    sub_serial_nbit_if #(.N(N)) bus ();

    sub_serial_nbit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] d, output logic bo, output logic ov);
        int sa;
        int sb;
        int r;
        d  = a - b;
        bo = (int'(a) < int'(b));
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa - sb;
        ov = (r > 127) || (r < -128);
    endfunction

    // Launches one subtraction and waits for done; lat is edges from accept to done, -1 on timeout
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic bo, output logic ov, output int lat);
        int cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            cnt++;
        end
        d  = bus.diff;
        bo = bus.borrow;
        ov = bus.ovf;
        lat = (bus.done === 1'b1) ? cnt - 1 : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 8'd100;
        bus.b = 8'd1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++;
        if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", bus.diff); end
        n_checks++;
        if (bus.borrow !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got borrow=%b ovf=%b want 0 0", bus.borrow, bus.ovf);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'd100, 8'd5, 8'h80, 8'd0, 8'hFF, 8'h7F};
        logic [7:0] tb_ [6] = '{8'd58, 8'd9, 8'h01, 8'd0, 8'h00, 8'hFF};
        logic [7:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb_[i], d, bo, ov, lat);
            model(ta[i], tb_[i], ed, ebo, eov);
            n_checks++;
            if (lat !== N) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, N); end
            n_checks++;
            if (d !== ed || bo !== ebo || ov !== eov) begin
                n_fail++;
                $display("FAIL dir_result[%0d] a=%h b=%h got diff=%h borrow=%b ovf=%b want diff=%h borrow=%b ovf=%b",
                         i, ta[i], tb_[i], d, bo, ov, ed, ebo, eov);
            end
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL dir_done_pulse[%0d] got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, d, ed;
        logic bo, ov, ebo, eov;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(a, b, d, bo, ov, lat);
            model(a, b, ed, ebo, eov);
            n_checks++;
            if (lat !== N || d !== ed || bo !== ebo || ov !== eov) begin
                n_fail++;
                $display("FAIL rand[%0d] a=%h b=%h got lat=%0d diff=%h borrow=%b ovf=%b want lat=%0d diff=%h borrow=%b ovf=%b",
                         i, a, b, lat, d, bo, ov, N, ed, ebo, eov);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [7:0] d = 8'hxx;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin dones++; d = bus.diff; end
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        n_checks++;
        if (d !== 8'd2) begin n_fail++; $display("FAIL ignore_diff got %h want 02", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed;
        logic ebo, eov;
        int cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd50; bus.b = 8'd80;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        model(8'd50, 8'd80, ed, ebo, eov);
        n_checks++;
        if (bus.done !== 1'b1 || bus.diff !== ed || bus.borrow !== ebo || bus.ovf !== eov) begin
            n_fail++;
            $display("FAIL b2b_first got done=%b diff=%h borrow=%b ovf=%b want done=1 diff=%h borrow=%b ovf=%b",
                     bus.done, bus.diff, bus.borrow, bus.ovf, ed, ebo, eov);
        end
        bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got %b want 1", bus.busy); end
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        n_checks++;
        if (cnt !== N + 1) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", cnt, N + 1); end
        n_checks++;
        if (bus.diff !== 8'd6 || bus.borrow !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got diff=%h borrow=%b ovf=%b want 06 0 0", bus.diff, bus.borrow, bus.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        logic [7:0] d;
        logic bo, ov;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd77; bus.b = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL rst_mid_diff got %h want 00", bus.diff); end
        for (int i = 0; i < N + 4; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
        run_op(8'd7, 8'd7, d, bo, ov, lat);
        n_checks++;
        if (lat !== N || d !== 8'h00 || bo !== 1'b0 || ov !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_after got lat=%0d diff=%h borrow=%b ovf=%b want %0d 00 0 0", lat, d, bo, ov, N);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
